stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Stack controller for the 8-bit core. It executes PUSH, POP, CALL and RET requests from the execute stage and maintains the stack pointer as an offset in 0..94. That offset drives the data address generator, which registers it and adds the 128 base, so the stack occupies memory bytes 128..222. The block also sequences the memory write strobes and captures read data for the stack window.

## Interface
Parameters:
- STACK_DEPTH, 95: number of stack bytes; offsets run 0..STACK_DEPTH-1.
- SP_TOP, 94: stack-pointer offset loaded at reset (address 222 after the generator).
- DATA_W, 8: data and PC width.

Ports:
- clk  in  1  single clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  request valid.
- op_ready  out  1  high only in IDLE.
- op_code  in  2  operation: 0 = PUSH, 1 = POP, 2 = CALL, 3 = RET.
- wr_data  in  8  byte to push (PUSH).
- call_pc  in  8  return PC (CALL).
- call_flags  in  4  CCR flags (CALL).
- stk_off  out  8  stack offset; connects to the address generator's data_addr_in.
- mem_we  out  1  write strobe, aligned with the generator's registered address.
- mem_wdata  out  8  write data, aligned with mem_we.
- mem_rdata  in  8  synchronous memory read data.
- pop_data  out  8  POP result.
- ret_pc  out  8  PC restored by RET.
- ret_flags  out  4  flags restored by RET.
- done  out  1  one-cycle pulse at the end of every accepted op.
- err  out  1  pulses with done when an op is rejected.
- depth  out  7  bytes currently on the stack, 0..95.

## Operation
- Reset values:
  - sp = SP_TOP; stk_off = SP_TOP; depth = 0.
  - op_ready = 1.
  - mem_we, done, err, pop_data, ret_pc, ret_flags, mem_wdata = 0.
  - FSM in IDLE.
- Handshake: an op is accepted on a cycle with op_valid && op_ready. Operands are latched at accept. op_valid while busy is ignored.
- The stack grows downward.
  - PUSH: write at sp, then sp = sp-1.
  - POP: sp = sp+1, then read at the new sp.
  - All sp arithmetic is modulo STACK_DEPTH: 0-1 gives 94, and 94+1 gives 0.
- CALL pushes call_pc first, then {4'b0, call_flags}. RET pops the flags byte first, then the PC.
- Rejection rules (no memory access, sp and depth unchanged):
  - PUSH when depth == 95.
  - CALL when depth > 93.
  - POP when depth == 0.
  - RET when depth < 2.
- FSM states: IDLE, WR, RD, RD_WAIT, DONE.
  - IDLE: accept an op, or stay in IDLE.
  - Accepted op passes the check, write op: go to WR.
  - Accepted op passes the check, read op: go to RD.
  - Accepted op fails the check: go to DONE with err set.
  - WR: one cycle per byte. Present stk_off = sp, then decrement sp. After the last byte, go to DONE.
  - RD: one cycle per byte, pipelined. Present stk_off = sp+1 (modulo STACK_DEPTH), then increment sp. After the last byte, go to RD_WAIT.
  - RD_WAIT: wait for the last read data to be captured, then go to DONE.
  - DONE: pulse done (and err if rejected), then return to IDLE.
- depth changes by ±1 per byte, in the same cycle as the sp update.
- stk_off holds its last value outside WR and RD.
- Sub-byte flags: ret_flags = captured byte[3:0]; bits [7:4] are ignored.

## Timing
Cycle 0 is the accept cycle.
- PUSH:
  - Cycle 1: WR, stk_off = sp.
  - Cycle 2: mem_we = 1, mem_wdata = wr_data, done = 1.
- CALL:
  - Cycles 1 and 2: WR, stk_off = sp, then sp-1.
  - Cycles 2 and 3: mem_we high, data = pc, then flags.
  - Cycle 3: done.
- mem_we and mem_wdata are registered once more than stk_off. This absorbs the generator's 1-cycle address register.
- Read latency: mem_rdata for an offset presented in cycle N is sampled at the end of cycle N+2 (1 cycle generator, 1 cycle RAM).
- POP: RD in cycle 1; data is captured at the end of cycle 3; pop_data and done are valid in cycle 4.
- RET: RD in cycles 1 and 2; flags are captured at the end of cycle 3 and the PC at the end of cycle 4; ret_pc, ret_flags and done are valid in cycle 5.
- Rejected op: done = err = 1 in cycle 1, with op_ready back to 1 in cycle 2.
- Reset mid-operation:
  - Returns to reset state on the next edge and drops the op.
  - The delayed mem_we is cleared, so no write is issued after rst.
- Outputs in flight are not completed. done is not pulsed for the aborted op.

## Structure
- Shared package:
  - op_code encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET).
  - STACK_DEPTH, SP_TOP, STACK_BASE = 128.
  - FSM state typedef.
- Sub-module stack_ptr: a modular up/down counter holding sp and depth. It has inc/dec inputs and full/empty/almost_full/almost_empty outputs.
- The top level holds the FSM, the write-alignment register and the read-capture pipeline.

## Test plan
- Reset, then PUSH 0xA5 → stk_off = 94 in cycle 1; mem_we with 0xA5 in cycle 2; done in cycle 2; depth = 1; sp = 93.
- Then POP → stk_off = 94 in cycle 1; model mem_rdata = 0xA5 at cycle 3; pop_data = 0xA5 and done in cycle 4; depth = 0.
- CALL pc = 0x3C, flags = 0x9 → writes 0x3C at offset 94 and 0x09 at offset 93. Then RET → ret_pc = 0x3C, ret_flags = 0x9 in cycle 5.
- Overflow and wrap:
  - 95 PUSHes → the 95th write goes to offset 0 and depth = 95.
  - A 96th PUSH → done + err in cycle 1, no mem_we, depth stays 95.
  - A following POP → reads offset 0.
- Empty stack: POP at depth 0 → err; RET at depth 1 → err; sp and depth unchanged.
- Reset mid-op: assert rst in cycle 1 of a CALL → no mem_we in any later cycle; stk_off = 94, depth = 0, op_ready = 1 on the next cycle.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: op encodings, stack geometry,
// FSM state type and modular offset helpers.
package stack_ctrl_pkg;

  localparam int STACK_DEPTH = 95;
  localparam int SP_TOP      = 94;
  localparam int STACK_BASE  = 128;
  localparam int PTR_W       = 7;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_DONE
  } state_e;

  // Offset + 1 wrapping from the last offset back to 0.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v,
                                                 input logic [PTR_W-1:0] last);
    return (v == last) ? '0 : v + PTR_W'(1);
  endfunction

  // Offset - 1 wrapping from 0 to the last offset.
  function automatic logic [PTR_W-1:0] wrap_dec(input logic [PTR_W-1:0] v,
                                                 input logic [PTR_W-1:0] last);
    return (v == '0) ? last : v - PTR_W'(1);
  endfunction

  // PUSH and CALL write memory; POP and RET read it.
  function automatic logic is_write_op(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_ctrl_ptr.sv
// Modular up/down counter for the stack pointer and the occupancy count.
// dec moves sp down (a byte was pushed), inc moves sp up (a byte was popped).
module stack_ptr #(
  parameter int STACK_DEPTH = 95,
  parameter int SP_TOP      = 94
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [6:0] sp,
  output logic [6:0] depth,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty
);
  import stack_ctrl_pkg::*;

  localparam logic [6:0] OFF_LAST  = 7'(STACK_DEPTH - 1);
  localparam logic [6:0] OFF_TOP   = 7'(SP_TOP);
  localparam logic [6:0] DEPTH_MAX = 7'(STACK_DEPTH);
  localparam logic [6:0] ONE       = 7'd1;
  localparam logic [6:0] TWO       = 7'd2;

  // Pointer and depth move together, one byte per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= OFF_TOP;
      depth <= '0;
    end else if (dec && !inc) begin
      sp    <= wrap_dec(sp, OFF_LAST);
      depth <= depth + ONE;
    end else if (inc && !dec) begin
      sp    <= wrap_inc(sp, OFF_LAST);
      depth <= depth - ONE;
    end
  end

  // Occupancy thresholds used for rejecting one- and two-byte ops.
  always_comb begin
    full         = (depth == DEPTH_MAX);
    empty        = (depth == '0);
    almost_full  = (depth > (DEPTH_MAX - TWO));
    almost_empty = (depth < TWO);
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: runs PUSH/POP/CALL/RET against the stack window, drives
// the offset to the address generator, aligns write strobes with its
// registered address and captures read data after the two-cycle read path.
module stack_ctrl #(
  parameter int STACK_DEPTH = 95,
  parameter int SP_TOP      = 94,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] call_pc,
  input  logic [3:0]        call_flags,
  output logic [7:0]        stk_off,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pop_data,
  output logic [DATA_W-1:0] ret_pc,
  output logic [3:0]        ret_flags,
  output logic              done,
  output logic              err,
  output logic [6:0]        depth
);
  import stack_ctrl_pkg::*;

  localparam logic [6:0] OFF_LAST = 7'(STACK_DEPTH - 1);
  localparam logic [6:0] OFF_TOP  = 7'(SP_TOP);

  state_e            state, next_state;
  op_e               op_in, op_q;
  logic [DATA_W-1:0] wr_q, pc_q, wbyte;
  logic [3:0]        flags_q;
  logic              err_q, byte_sel, last_byte;
  logic              accept, reject;
  logic              ptr_inc, ptr_dec;
  logic              full, empty, almost_full, almost_empty;
  logic [6:0]        sp, off_hold, cur_off;
  logic [1:0]        rd_vld, rd_sel;

  assign op_in = op_e'(op_code);

  stack_ptr #(
    .STACK_DEPTH (STACK_DEPTH),
    .SP_TOP      (SP_TOP)
  ) u_ptr (
    .clk          (clk),
    .rst          (rst),
    .inc          (ptr_inc),
    .dec          (ptr_dec),
    .sp           (sp),
    .depth        (depth),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // Decide whether the incoming op would overflow or underflow the stack.
  always_comb begin
    reject = 1'b0;
    case (op_in)
      OP_PUSH: reject = full;
      OP_POP:  reject = empty;
      OP_CALL: reject = almost_full;
      OP_RET:  reject = almost_empty;
      default: reject = 1'b0;
    endcase
  end

  // Single-byte ops finish after their first byte, CALL/RET after the second.
  always_comb begin
    last_byte = (op_q == OP_PUSH) || (op_q == OP_POP) || byte_sel;
    if (op_q == OP_PUSH)
      wbyte = wr_q;
    else if (byte_sel)
      wbyte = {{(DATA_W-4){1'b0}}, flags_q};
    else
      wbyte = pc_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // Next state, handshake, pointer moves and the presented offset.
  always_comb begin
    next_state = state;
    op_ready   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    accept     = 1'b0;
    ptr_inc    = 1'b0;
    ptr_dec    = 1'b0;
    cur_off    = off_hold;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept = 1'b1;
          if (reject)
            next_state = ST_DONE;
          else if (is_write_op(op_in))
            next_state = ST_WR;
          else
            next_state = ST_RD;
        end
      end
      ST_WR: begin
        ptr_dec = 1'b1;
        cur_off = sp;
        if (last_byte)
          next_state = ST_DONE;
      end
      ST_RD: begin
        ptr_inc = 1'b1;
        cur_off = wrap_inc(sp, OFF_LAST);
        if (last_byte)
          next_state = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_vld[1] && !rd_vld[0])
          next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        err        = err_q;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign stk_off = {1'b0, cur_off};

  // Operand latch, write alignment one cycle behind the offset, and the
  // read-capture pipeline that tracks each read through generator and RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_PUSH;
      wr_q      <= '0;
      pc_q      <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      byte_sel  <= 1'b0;
      off_hold  <= OFF_TOP;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rd_vld    <= '0;
      rd_sel    <= '0;
      pop_data  <= '0;
      ret_pc    <= '0;
      ret_flags <= '0;
    end else begin
      if (accept) begin
        op_q     <= op_in;
        wr_q     <= wr_data;
        pc_q     <= call_pc;
        flags_q  <= call_flags;
        err_q    <= reject;
        byte_sel <= 1'b0;
      end
      if ((state == ST_WR) || (state == ST_RD)) begin
        byte_sel <= 1'b1;
        off_hold <= cur_off;
      end
      mem_we <= (state == ST_WR);
      if (state == ST_WR)
        mem_wdata <= wbyte;
      rd_vld <= {rd_vld[0], (state == ST_RD)};
      rd_sel <= {rd_sel[0], byte_sel};
      if (rd_vld[1]) begin
        if (op_q == OP_POP)
          pop_data <= mem_rdata;
        else if (!rd_sel[1])
          ret_flags <= mem_rdata[3:0];
        else
          ret_pc <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: address generator + RAM model around the DUT,
// directed scenarios and a randomized run against a queue-based stack model.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, op_valid, op_ready;
  logic [1:0] op_code;
  logic [7:0] wr_data, call_pc, stk_off, mem_wdata, mem_rdata, pop_data, ret_pc;
  logic [3:0] call_flags, ret_flags;
  logic       mem_we, done, err;
  logic [6:0] depth;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .wr_data    (wr_data),
    .call_pc    (call_pc),
    .call_flags (call_flags),
    .stk_off    (stk_off),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pop_data   (pop_data),
    .ret_pc     (ret_pc),
    .ret_flags  (ret_flags),
    .done       (done),
    .err        (err),
    .depth      (depth)
  );

  // Address generator (registered offset + base) feeding a synchronous RAM.
  logic [7:0] ga_addr;
  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  always @(posedge clk) begin
    ga_addr <= stk_off + 8'(STACK_BASE);
    if (mem_we) ram[ga_addr] <= mem_wdata;
    mem_rdata <= ram[ga_addr];
  end

  // Reference model: the stack as a queue of bytes, last element on top.
  logic [7:0] model[$];
  logic [7:0] m_pop, m_rpc;
  logic [3:0] m_rf;

  // Observations from one op.
  int         o_done_cyc, o_nwe, o_depth;
  int         o_we_off [2];
  int         o_we_cyc [2];
  logic [7:0] o_we_dat [2];
  logic [7:0] o_off1, o_pop, o_rpc;
  logic [3:0] o_rf;
  logic       o_err, o_ready_after, o_acc_ready;

  // Expectations from the model for one op.
  logic       e_err;
  int         e_done, e_nwe, e_off1, e_woff0;
  logic [7:0] e_wd0, e_wd1;

  task automatic ref_op(input logic [1:0] c, input logic [7:0] d,
                        input logic [7:0] pc, input logic [3:0] f);
    int sz, sp;
    logic [7:0] t;
    sz = model.size();
    sp = (SP_TOP - sz + STACK_DEPTH) % STACK_DEPTH;
    e_err = 1'b0; e_nwe = 0; e_off1 = -1; e_woff0 = -1; e_wd0 = 8'h00; e_wd1 = 8'h00;
    case (c)
      2'd0: if (sz == STACK_DEPTH) e_err = 1'b1;
            else begin
              e_done = 2; e_nwe = 1; e_off1 = sp; e_woff0 = sp; e_wd0 = d;
              model.push_back(d);
            end
      2'd2: if (sz > STACK_DEPTH - 2) e_err = 1'b1;
            else begin
              e_done = 3; e_nwe = 2; e_off1 = sp; e_woff0 = sp;
              e_wd0 = pc; e_wd1 = {4'h0, f};
              model.push_back(pc); model.push_back({4'h0, f});
            end
      2'd1: if (sz == 0) e_err = 1'b1;
            else begin
              e_done = 4; e_off1 = (sp + 1) % STACK_DEPTH;
              m_pop = model.pop_back();
            end
      default: if (sz < 2) e_err = 1'b1;
            else begin
              e_done = 5; e_off1 = (sp + 1) % STACK_DEPTH;
              t = model.pop_back(); m_rf = t[3:0];
              m_rpc = model.pop_back();
            end
    endcase
    if (e_err) e_done = 1;
  endtask

  task automatic run_op(input logic [1:0] c, input logic [7:0] d,
                        input logic [7:0] pc, input logic [3:0] f);
    @(negedge clk);
    op_code = c; wr_data = d; call_pc = pc; call_flags = f; op_valid = 1'b1;
    o_acc_ready = op_ready;
    @(negedge clk);
    op_valid = 1'b0;
    o_off1 = stk_off; o_done_cyc = -1; o_err = 1'b0; o_nwe = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (mem_we) begin
        if (o_nwe < 2) begin
          o_we_off[o_nwe] = int'(ga_addr) - STACK_BASE;
          o_we_dat[o_nwe] = mem_wdata;
          o_we_cyc[o_nwe] = cyc;
        end
        o_nwe++;
      end
      if (done) begin
        o_done_cyc = cyc; o_err = err;
        o_pop = pop_data; o_rpc = ret_pc; o_rf = ret_flags;
        break;
      end
    end
    @(negedge clk);
    o_ready_after = op_ready;
    o_depth = int'(depth);
    if (mem_we) o_nwe++;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_code = 2'd0;
    wr_data = 8'h00; call_pc = 8'h00; call_flags = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if ({op_ready, stk_off, depth} !== {1'b1, 8'd94, 7'd0}) begin
      errors++; $display("[TB] FAIL reset_ptr got ready=%0b off=%0d depth=%0d want 1/94/0", op_ready, stk_off, depth);
    end
    checks++; if ({mem_we, done, err, mem_wdata} !== 11'd0) begin
      errors++; $display("[TB] FAIL reset_strobes got we=%0b done=%0b err=%0b wdata=%0h want 0", mem_we, done, err, mem_wdata);
    end
    checks++; if ({pop_data, ret_pc, ret_flags} !== 20'd0) begin
      errors++; $display("[TB] FAIL reset_results got pop=%0h pc=%0h flags=%0h want 0", pop_data, ret_pc, ret_flags);
    end
    rst = 1'b0;
    model.delete(); m_pop = 8'h00; m_rpc = 8'h00; m_rf = 4'h0;
  endtask

  task automatic test_push_pop();
    ref_op(2'd0, 8'hA5, 8'h00, 4'h0);
    run_op(2'd0, 8'hA5, 8'h00, 4'h0);
    checks++; if (o_off1 !== 8'd94) begin errors++; $display("[TB] FAIL push_off got %0d want 94", o_off1); end
    checks++; if (o_nwe != 1 || o_we_cyc[0] != 2 || o_we_dat[0] !== 8'hA5 || o_we_off[0] != 94) begin
      errors++; $display("[TB] FAIL push_write got n=%0d cyc=%0d data=%0h off=%0d want 1/2/a5/94", o_nwe, o_we_cyc[0], o_we_dat[0], o_we_off[0]);
    end
    checks++; if (o_done_cyc != 2 || o_err !== 1'b0 || o_depth != 1) begin
      errors++; $display("[TB] FAIL push_done got cyc=%0d err=%0b depth=%0d want 2/0/1", o_done_cyc, o_err, o_depth);
    end
    ref_op(2'd1, 8'h00, 8'h00, 4'h0);
    run_op(2'd1, 8'h00, 8'h00, 4'h0);
    checks++; if (o_off1 !== 8'd94) begin errors++; $display("[TB] FAIL pop_off got %0d want 94", o_off1); end
    checks++; if (o_done_cyc != 4 || o_pop !== 8'hA5 || o_depth != 0 || o_nwe != 0) begin
      errors++; $display("[TB] FAIL pop_result got cyc=%0d data=%0h depth=%0d nwe=%0d want 4/a5/0/0", o_done_cyc, o_pop, o_depth, o_nwe);
    end
  endtask

  task automatic test_call_ret();
    ref_op(2'd2, 8'h00, 8'h3C, 4'h9);
    run_op(2'd2, 8'h00, 8'h3C, 4'h9);
    checks++; if (o_nwe != 2 || o_we_off[0] != 94 || o_we_off[1] != 93 || o_we_dat[0] !== 8'h3C || o_we_dat[1] !== 8'h09) begin
      errors++; $display("[TB] FAIL call_writes got n=%0d off=%0d,%0d data=%0h,%0h want 2 94,93 3c,09", o_nwe, o_we_off[0], o_we_off[1], o_we_dat[0], o_we_dat[1]);
    end
    checks++; if (o_we_cyc[0] != 2 || o_we_cyc[1] != 3 || o_done_cyc != 3 || o_depth != 2) begin
      errors++; $display("[TB] FAIL call_timing got we=%0d,%0d done=%0d depth=%0d want 2,3 3 2", o_we_cyc[0], o_we_cyc[1], o_done_cyc, o_depth);
    end
    ref_op(2'd3, 8'h00, 8'h00, 4'h0);
    run_op(2'd3, 8'h00, 8'h00, 4'h0);
    checks++; if (o_done_cyc != 5 || o_rpc !== 8'h3C || o_rf !== 4'h9 || o_depth != 0 || o_off1 !== 8'd93) begin
      errors++; $display("[TB] FAIL ret_result got cyc=%0d pc=%0h flags=%0h depth=%0d off=%0d want 5/3c/9/0/93", o_done_cyc, o_rpc, o_rf, o_depth, o_off1);
    end
  endtask

  task automatic test_empty();
    ref_op(2'd1, 8'h00, 8'h00, 4'h0);
    run_op(2'd1, 8'h00, 8'h00, 4'h0);
    checks++; if (o_err !== 1'b1 || o_done_cyc != 1 || o_nwe != 0 || o_depth != 0 || o_ready_after !== 1'b1) begin
      errors++; $display("[TB] FAIL pop_empty got err=%0b cyc=%0d nwe=%0d depth=%0d ready=%0b want 1/1/0/0/1", o_err, o_done_cyc, o_nwe, o_depth, o_ready_after);
    end
    ref_op(2'd0, 8'h11, 8'h00, 4'h0);
    run_op(2'd0, 8'h11, 8'h00, 4'h0);
    checks++; if (o_we_off[0] != 94 || o_err !== 1'b0) begin
      errors++; $display("[TB] FAIL sp_after_reject got off=%0d err=%0b want 94/0", o_we_off[0], o_err);
    end
    ref_op(2'd3, 8'h00, 8'h00, 4'h0);
    run_op(2'd3, 8'h00, 8'h00, 4'h0);
    checks++; if (o_err !== 1'b1 || o_done_cyc != 1 || o_depth != 1) begin
      errors++; $display("[TB] FAIL ret_depth1 got err=%0b cyc=%0d depth=%0d want 1/1/1", o_err, o_done_cyc, o_depth);
    end
    ref_op(2'd1, 8'h00, 8'h00, 4'h0);
    run_op(2'd1, 8'h00, 8'h00, 4'h0);
    checks++; if (o_pop !== 8'h11 || o_off1 !== 8'd94 || o_depth != 0) begin
      errors++; $display("[TB] FAIL pop_after_ret_reject got data=%0h off=%0d depth=%0d want 11/94/0", o_pop, o_off1, o_depth);
    end
  endtask

  task automatic test_overflow_wrap();
    int bad;
    logic [7:0] d, last;
    bad = 0; last = 8'h00;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      d = 8'($urandom);
      last = d;
      ref_op(2'd0, d, 8'h00, 4'h0);
      run_op(2'd0, d, 8'h00, 4'h0);
      if (o_err !== 1'b0 || o_we_off[0] != e_woff0 || o_we_dat[0] !== d) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fill_pushes got %0d bad pushes want 0", bad); end
    checks++; if (o_we_off[0] != 0 || o_depth != 95) begin
      errors++; $display("[TB] FAIL push95 got off=%0d depth=%0d want 0/95", o_we_off[0], o_depth);
    end
    ref_op(2'd0, 8'h5A, 8'h00, 4'h0);
    run_op(2'd0, 8'h5A, 8'h00, 4'h0);
    checks++; if (o_err !== 1'b1 || o_done_cyc != 1 || o_nwe != 0 || o_depth != 95) begin
      errors++; $display("[TB] FAIL push_full got err=%0b cyc=%0d nwe=%0d depth=%0d want 1/1/0/95", o_err, o_done_cyc, o_nwe, o_depth);
    end
    ref_op(2'd1, 8'h00, 8'h00, 4'h0);
    run_op(2'd1, 8'h00, 8'h00, 4'h0);
    checks++; if (o_off1 !== 8'd0 || o_pop !== last || o_depth != 94) begin
      errors++; $display("[TB] FAIL pop_wrap got off=%0d data=%0h depth=%0d want 0/%0h/94", o_off1, o_pop, o_depth, last);
    end
    ref_op(2'd2, 8'h00, 8'h77, 4'h3);
    run_op(2'd2, 8'h00, 8'h77, 4'h3);
    checks++; if (o_err !== 1'b1 || o_nwe != 0 || o_depth != 94) begin
      errors++; $display("[TB] FAIL call_depth94 got err=%0b nwe=%0d depth=%0d want 1/0/94", o_err, o_nwe, o_depth);
    end
  endtask

  task automatic test_reset_midop();
    int stray;
    @(negedge clk);
    op_code = 2'd2; call_pc = 8'hC3; call_flags = 4'hF; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if ({mem_we, done, op_ready, stk_off, depth} !== {1'b0, 1'b0, 1'b1, 8'd94, 7'd0}) begin
      errors++; $display("[TB] FAIL midop_reset got we=%0b done=%0b ready=%0b off=%0d depth=%0d want 0/0/1/94/0", mem_we, done, op_ready, stk_off, depth);
    end
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || done !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL midop_stray got %0d cycles with we/done want 0", stray); end
    model.delete(); m_pop = 8'h00; m_rpc = 8'h00; m_rf = 4'h0;
  endtask

  task automatic test_random();
    int r;
    logic [1:0] c;
    logic [7:0] d, pc;
    logic [3:0] f;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      c = (r < 4) ? 2'd0 : (r < 5) ? 2'd2 : (r < 8) ? 2'd1 : 2'd3;
      d = 8'($urandom); pc = 8'($urandom); f = 4'($urandom);
      ref_op(c, d, pc, f);
      run_op(c, d, pc, f);
      checks++; if (o_err !== e_err || o_done_cyc != e_done || o_nwe != e_nwe || o_acc_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL rand_ctrl op=%0d got err=%0b cyc=%0d nwe=%0d want %0b/%0d/%0d", c, o_err, o_done_cyc, o_nwe, e_err, e_done, e_nwe);
      end
      checks++; if (o_depth != model.size() || o_pop !== m_pop || o_rpc !== m_rpc || o_rf !== m_rf) begin
        errors++; $display("[TB] FAIL rand_state op=%0d got depth=%0d pop=%0h pc=%0h fl=%0h want %0d/%0h/%0h/%0h", c, o_depth, o_pop, o_rpc, o_rf, model.size(), m_pop, m_rpc, m_rf);
      end
      if (!e_err) begin
        checks++; if (int'(o_off1) != e_off1) begin
          errors++; $display("[TB] FAIL rand_off op=%0d got %0d want %0d", c, o_off1, e_off1);
        end
      end
      if (e_nwe > 0) begin
        checks++; if (o_we_off[0] != e_woff0 || o_we_dat[0] !== e_wd0 || (e_nwe == 2 && o_we_dat[1] !== e_wd1)) begin
          errors++; $display("[TB] FAIL rand_write op=%0d got off=%0d d=%0h,%0h want %0d %0h,%0h", c, o_we_off[0], o_we_dat[0], o_we_dat[1], e_woff0, e_wd0, e_wd1);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_call_ret();
    test_empty();
    test_overflow_wrap();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
